uart_tx_sched: RTL

Round-robin scheduler that shares one `uart_tx` transmitter among `NUM_REQ` byte producers. It sits between the producers and `uart_tx`. It accepts one byte at a time over a valid/ready handshake, issues a single-cycle `tx_start` with the byte, tracks `tx_busy` through the frame, and enforces an optional inter-frame idle gap measured in baud ticks. It then grants the next requester in rotation.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 32 +++
 rtl/uart_tx_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, byte width and a width helper
// used by uart_tx_sched, frame_gen and uart_tx.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_GAP       = ST_GAP
  } sched_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins,
// wrapping modulo N (N need not be a power of two).
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // ptr < N and offset < N, so one conditional subtract replaces a modulo.
  function automatic int wrap(input int s);
    return (s >= N) ? s - N : s;
  endfunction

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Scan from the farthest offset down so the closest request to ptr is kept last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap(int'(ptr) + i)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(wrap(int'(ptr) + i));
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers, with an
// optional idle gap of GAP_TICKS baud ticks after each frame.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int GAP_TICKS = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           baud_tick,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           sched_busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = idx_w(GAP_TICKS + 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  sched_state_e            state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic                    busy_q, busy_d;

  logic                    gnt_valid;
  logic [ID_W-1:0]         gnt_idx;
  logic [UART_DATA_W-1:0]  win_byte;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) win_byte = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gap_d       = gap_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    req_ready_d = '0;
    grant_d     = grant_q;

    unique case (state_q)
      S_IDLE: begin
        // A busy transmitter in IDLE is a protocol error; never start over it.
        if (gnt_valid && !tx_busy) begin
          tx_data_d            = win_byte;
          grant_d              = gnt_idx;
          ptr_d                = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
          tx_start_d           = 1'b1;
          req_ready_d[gnt_idx] = 1'b1;
          state_d              = S_START;
        end
      end
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_TICKS == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (baud_tick) begin
          if (gap_q == GAP_LAST) state_d = S_IDLE;
          else                   gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gap_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      req_ready_q <= req_ready_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign req_ready  = req_ready_q;
  assign grant_id   = grant_q;
  assign sched_busy = busy_q;

endmodule
